pie_tx: RTL and testbench
=========================

# pie_tx

Reader-side PIE (pulse-interval encoding) line transmitter for the 6C (ISO 18000-6C / EPC Gen2) link, running on the 50 MHz system clock. It drives the reader-to-tag line `rd_data` that the tag-side receiver and reset detector sample. It generates three things:
- the Gen2 preamble or frame-sync;
- PIE data symbols pulled through a valid/ready bit stream;
- a long-low reset burst, which the tag's reset detector must recognise as a power-down reset.

Between operations the line idles high (CW).

## Interface
Parameters (all counts in `clk_50m` cycles):
- `TARI`, 625: data-0 symbol length (12.5 us).
- `DATA1`, 1250: data-1 symbol length (2 Tari).
- `PW`, 313: low pulse width ending every symbol; must be < `TARI`.
- `DELIM`, 625: delimiter low length.
- `TRCAL`, 3000: TRcal symbol length.
- `RST_LOW`, 6000: reset burst low length. Must exceed 5002 so the tag detector's 5000-cycle threshold is crossed.
- `CW`, 16 bits: width of every counter.

Ports:
- `clk_50m` in 1: system clock. One clock domain; every flop is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_start` in 1: one-cycle request to send a frame; sampled in IDLE only.
- `tx_pre` in 1: latched with `tx_start`. 1 = preamble (includes TRcal); 0 = frame-sync.
- `tx_rst_req` in 1: one-cycle request for a reset burst; accepted in any state.
- `bit_data` in 1: next data bit.
- `bit_valid` in 1: `bit_data` is valid.
- `bit_last` in 1: qualifies `bit_data`; marks the final bit of the frame.
- `bit_ready` out 1: one-cycle pulse; the bit is consumed when `bit_valid & bit_ready`.
- `rd_data` out 1: PIE line, registered output.
- `tx_busy` out 1: high whenever not IDLE.
- `tx_done` out 1: one-cycle pulse at the end of a frame or burst.
- `tx_err` out 1: one-cycle pulse on bit underrun.

## Operation
- Reset values: `rd_data`=1, `tx_busy`=0, `tx_done`=0, `tx_err`=0, `bit_ready`=0, state IDLE.
- States and transitions: IDLE → DELIM → D0 → RTCAL → [TRCAL if `tx_pre`] → DATA → IDLE. RSTLOW → IDLE.
- Symbol of length L: `rd_data` high for L−PW cycles, then low for PW cycles.
- RTCAL length is `TARI+DATA1` (localparam).
- DELIM: `rd_data` low for `DELIM` cycles, with no high phase.
- DATA:
  - `bit_ready` pulses in the cycle a data symbol is loaded (the first DATA cycle, and the cycle after each symbol's last low cycle).
  - If `bit_valid`=1 there, the symbol length is `bit_data ? DATA1 : TARI`. The bit's `bit_last` is stored.
  - After the symbol carrying `bit_last`, the FSM goes to IDLE, `rd_data` returns high and `tx_done` pulses.
- Underrun: `bit_valid`=0 at a load cycle → `tx_err` pulses, `rd_data` goes high, FSM goes to IDLE, no `tx_done`.
- RSTLOW: `rd_data` low for `RST_LOW` cycles, then high, `tx_done` pulses, IDLE.
- `tx_rst_req` in any non-IDLE state aborts the current operation and enters RSTLOW next cycle. There is no `tx_done` for the aborted frame.
- `tx_rst_req` and `tx_start` in the same cycle: the reset burst wins and `tx_start` is dropped.
- `tx_start` while busy is ignored.
- `rst_n` low mid-operation: all outputs return to their reset values immediately; the counters clear.

## Timing
- Output latency: `rd_data` changes 1 cycle after the request is sampled. `tx_start` at cycle 0 → `rd_data` low from cycle 1 through cycle `DELIM`.
- Symbols are back-to-back, with no idle cycle between symbols or between the delimiter and D0.
- Frame length, where `Lbits` is the sum of the data symbol lengths:
  - preamble: `DELIM+TARI+RTCAL+TRCAL+Lbits`;
  - frame-sync: the same without `TRCAL`.
- `tx_done` is asserted in the first cycle `rd_data` is high again. `tx_busy` falls in the same cycle.
- Counter arithmetic:
  - the down-counter loads L−1 and changes phase at count `PW−1`;
  - a phase flip at an off-by-one position is a bug;
  - there is no wrap-around: every length must be < 2^CW.

## Structure
- Shared 6C package holds:
  - the state encoding (`PIE_IDLE`, `PIE_DELIM`, `PIE_D0`, `PIE_RTCAL`, `PIE_TRCAL`, `PIE_DATA`, `PIE_RSTLOW`);
  - the default timing constants, which are shared with the tag-side receiver and reset detector.
- One sub-module, `pie_sym_gen`:
  - inputs: load, length, `low_only`;
  - outputs: line level and a `sym_end` pulse;
  - owns the down-counter.
- The top level holds the FSM and the bit handshake.

## Test plan
- Frame-sync, bits 1,0 (`bit_last` on the second bit) → low 625, high 312/low 313 (D0), high 1562/low 313 (RTcal), high 937/low 313, high 312/low 313, then high. `tx_done` pulses once; `bit_ready` pulses exactly twice.
- Preamble with 1 bit → a TRcal phase of high 2687/low 313 appears between RTcal and the data symbol; the total frame is 7375 cycles.
- `tx_rst_req` from IDLE → `rd_data` low for exactly 6000 cycles. A tag reset detector connected in loopback asserts `sys_rst`.
- `tx_rst_req` in the middle of the RTcal symbol → RSTLOW starts next cycle. There is no `tx_done` for the frame; `tx_done` pulses once, after 6000 low cycles.
- `bit_valid`=0 at the first data load → `tx_err` pulse, `rd_data`=1 the next cycle, `tx_busy`=0, no `tx_done`.
- `rst_n` asserted during the delimiter → `rd_data`=1 and `tx_busy`=0 immediately. After release, the next `tx_start` produces a complete, correctly timed frame.

Source files
------------

// File: rtl/pie_tx_pkg.sv
// ---------------------------------------------------------------------------
// pie_tx_pkg : 6C PIE state encoding and timing defaults shared with tag side
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pie_tx_pkg;

  localparam int unsigned C_TARI    = 625;
  localparam int unsigned C_DATA1   = 1250;
  localparam int unsigned C_PW      = 313;
  localparam int unsigned C_DELIM   = 625;
  localparam int unsigned C_TRCAL   = 3000;
  localparam int unsigned C_RST_LOW = 6000;
  localparam int unsigned C_CW      = 16;

  typedef enum logic [2:0] {
    PIE_IDLE   = 3'd0,
    PIE_DELIM  = 3'd1,
    PIE_D0     = 3'd2,
    PIE_RTCAL  = 3'd3,
    PIE_TRCAL  = 3'd4,
    PIE_DATA   = 3'd5,
    PIE_RSTLOW = 3'd6
  } pie_state_e;

endpackage

`default_nettype wire

// File: rtl/pie_tx_sym_gen.sv
// ---------------------------------------------------------------------------
// pie_sym_gen : one PIE symbol (high L-PW, low PW) or a low-only interval
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pie_sym_gen
  import pie_tx_pkg::*;
#(
  parameter int unsigned PW = C_PW,
  parameter int unsigned CW = C_CW
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          late_i,
  input  logic          low_only_i,
  input  logic [CW-1:0] len_i,
  output logic          line_o,
  output logic          sym_end_o
);

  localparam logic [CW-1:0] C_PW_W = CW'(PW);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] w_start;
  logic          act_q, act_d;
  logic          lo_q, lo_d;
  logic          line_q, line_d;

  always_comb begin
    // a late load arrives in the symbol's first cycle, which is already shown high
    w_start   = late_i ? (len_i - C_TWO) : (len_i - C_ONE);
    cnt_d     = cnt_q;
    act_d     = act_q;
    lo_d      = lo_q;
    line_d    = line_q;
    sym_end_o = act_q && (cnt_q == '0);
    if (load_i) begin
      cnt_d  = w_start;
      act_d  = 1'b1;
      lo_d   = low_only_i;
      line_d = !low_only_i && (w_start >= C_PW_W);
    end else if (sym_end_o) begin
      act_d  = 1'b0;
      line_d = 1'b1;
    end else if (act_q) begin
      cnt_d  = cnt_q - C_ONE;
      line_d = !lo_q && (cnt_d >= C_PW_W);
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= 1'b0;
      lo_q   <= 1'b0;
      line_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      lo_q   <= lo_d;
      line_q <= line_d;
    end
  end

  assign line_o = line_q;

endmodule

`default_nettype wire

// File: rtl/pie_tx.sv
// ---------------------------------------------------------------------------
// pie_tx : Gen2 reader PIE transmitter (preamble/frame-sync, data, reset burst)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pie_tx
  import pie_tx_pkg::*;
#(
  parameter int unsigned TARI    = C_TARI,
  parameter int unsigned DATA1   = C_DATA1,
  parameter int unsigned PW      = C_PW,
  parameter int unsigned DELIM   = C_DELIM,
  parameter int unsigned TRCAL   = C_TRCAL,
  parameter int unsigned RST_LOW = C_RST_LOW,
  parameter int unsigned CW      = C_CW
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic tx_start,
  input  logic tx_pre,
  input  logic tx_rst_req,
  input  logic bit_data,
  input  logic bit_valid,
  input  logic bit_last,
  output logic bit_ready,
  output logic rd_data,
  output logic tx_busy,
  output logic tx_done,
  output logic tx_err
);

  localparam logic [CW-1:0] C_L_TARI  = CW'(TARI);
  localparam logic [CW-1:0] C_L_DATA1 = CW'(DATA1);
  localparam logic [CW-1:0] C_L_DELIM = CW'(DELIM);
  localparam logic [CW-1:0] C_L_RTCAL = CW'(TARI + DATA1);
  localparam logic [CW-1:0] C_L_TRCAL = CW'(TRCAL);
  localparam logic [CW-1:0] C_L_RST   = CW'(RST_LOW);

  pie_state_e    state_q, state_d;
  logic          pre_q, pre_d;
  logic          last_q, last_d;
  logic          slot_q, slot_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          w_load;
  logic          w_late;
  logic          w_low_only;
  logic [CW-1:0] w_len;
  logic          w_line;
  logic          w_sym_end;

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    last_d     = last_q;
    slot_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    w_load     = 1'b0;
    w_late     = 1'b0;
    w_low_only = 1'b0;
    w_len      = '0;
    bit_ready  = 1'b0;
    if (tx_rst_req) begin
      state_d    = PIE_RSTLOW;
      w_load     = 1'b1;
      w_low_only = 1'b1;
      w_len      = C_L_RST;
    end else begin
      case (state_q)
        PIE_IDLE: begin
          if (tx_start) begin
            state_d    = PIE_DELIM;
            pre_d      = tx_pre;
            w_load     = 1'b1;
            w_low_only = 1'b1;
            w_len      = C_L_DELIM;
          end
        end
        PIE_DELIM: begin
          if (w_sym_end) begin
            state_d = PIE_D0;
            w_load  = 1'b1;
            w_len   = C_L_TARI;
          end
        end
        PIE_D0: begin
          if (w_sym_end) begin
            state_d = PIE_RTCAL;
            w_load  = 1'b1;
            w_len   = C_L_RTCAL;
          end
        end
        PIE_RTCAL: begin
          if (w_sym_end) begin
            if (pre_q) begin
              state_d = PIE_TRCAL;
              w_load  = 1'b1;
              w_len   = C_L_TRCAL;
            end else begin
              state_d = PIE_DATA;
              slot_d  = 1'b1;
            end
          end
        end
        PIE_TRCAL: begin
          if (w_sym_end) begin
            state_d = PIE_DATA;
            slot_d  = 1'b1;
          end
        end
        PIE_DATA: begin
          // slot_q marks the load cycle: line already high, length chosen now
          if (slot_q) begin
            bit_ready = 1'b1;
            if (bit_valid) begin
              w_load = 1'b1;
              w_late = 1'b1;
              w_len  = bit_data ? C_L_DATA1 : C_L_TARI;
              last_d = bit_last;
            end else begin
              state_d = PIE_IDLE;
              err_d   = 1'b1;
            end
          end else if (w_sym_end) begin
            if (last_q) begin
              state_d = PIE_IDLE;
              done_d  = 1'b1;
            end else begin
              slot_d = 1'b1;
            end
          end
        end
        PIE_RSTLOW: begin
          if (w_sym_end) begin
            state_d = PIE_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = PIE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PIE_IDLE;
      pre_q   <= 1'b0;
      last_q  <= 1'b0;
      slot_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      last_q  <= last_d;
      slot_q  <= slot_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  pie_sym_gen #(
    .PW (PW),
    .CW (CW)
  ) u_sym_gen (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .load_i     (w_load),
    .late_i     (w_late),
    .low_only_i (w_low_only),
    .len_i      (w_len),
    .line_o     (w_line),
    .sym_end_o  (w_sym_end)
  );

  assign rd_data = w_line;
  assign tx_busy = (state_q != PIE_IDLE);
  assign tx_done = done_q;
  assign tx_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pie_tx.sv
// ---------------------------------------------------------------------------
// tb_pie_tx : self-checking bench for pie_tx against a segment-level line model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pie_tx;

  localparam int TARI    = 625;
  localparam int DATA1   = 1250;
  localparam int PW      = 313;
  localparam int DELIM   = 625;
  localparam int TRCAL   = 3000;
  localparam int RST_LOW = 6000;

  logic clk_50m;
  logic rst_n;
  logic tx_start, tx_pre, tx_rst_req;
  logic bit_data, bit_valid, bit_last;
  logic bit_ready, rd_data, tx_busy, tx_done, tx_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic rdt[$];
  logic dnt[$];
  logic byt[$];
  logic ert[$];
  logic ryt[$];
  bit   exp_q[$];

  bit bits_a[8];
  int nbits;
  int idx;
  bit prev_ready;
  bit src_valid;
  int abort_at;
  int spur_start_at;

  pie_tx #(
    .TARI    (TARI),
    .DATA1   (DATA1),
    .PW      (PW),
    .DELIM   (DELIM),
    .TRCAL   (TRCAL),
    .RST_LOW (RST_LOW),
    .CW      (16)
  ) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .tx_start   (tx_start),
    .tx_pre     (tx_pre),
    .tx_rst_req (tx_rst_req),
    .bit_data   (bit_data),
    .bit_valid  (bit_valid),
    .bit_last   (bit_last),
    .bit_ready  (bit_ready),
    .rd_data    (rd_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  // Line model: a frame is a list of (level, length) segments
  function automatic void push_lvl(bit l, int n);
    for (int k = 0; k < n; k++) exp_q.push_back(l);
  endfunction

  function automatic void push_sym(int len);
    push_lvl(1'b1, len - PW);
    push_lvl(1'b0, PW);
  endfunction

  function automatic void build_frame(bit pre);
    exp_q.delete();
    push_lvl(1'b0, DELIM);
    push_sym(TARI);
    push_sym(TARI + DATA1);
    if (pre) push_sym(TRCAL);
    for (int k = 0; k < nbits; k++) push_sym(bits_a[k] ? DATA1 : TARI);
  endfunction

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic present();
    if (idx < nbits) begin
      bit_valid = src_valid;
      bit_data  = bits_a[idx];
      bit_last  = (idx == nbits - 1);
    end else begin
      bit_valid = 1'b0;
      bit_data  = 1'b0;
      bit_last  = 1'b0;
    end
  endtask

  // Trace index k holds the outputs seen in cycle k+1 after the request cycle
  task automatic capture(input int n);
    rdt.delete(); dnt.delete(); byt.delete(); ert.delete(); ryt.delete();
    prev_ready = 1'b0;
    for (int c = 1; c <= n; c++) begin
      step();
      if (prev_ready && bit_valid) idx++;
      tx_start   = (c == spur_start_at);
      tx_rst_req = (c == abort_at);
      present();
      rdt.push_back(rd_data);
      dnt.push_back(tx_done);
      byt.push_back(tx_busy);
      ert.push_back(tx_err);
      ryt.push_back(bit_ready);
      prev_ready = bit_ready;
    end
    tx_start   = 1'b0;
    tx_rst_req = 1'b0;
  endtask

  task automatic check_frame(input string nm, input int exp_ready);
    int L, bad, dc, rc, ec;
    bit busy_ok;
    L = exp_q.size();
    bad = -1;
    for (int c = 0; c < L; c++)
      if (bad < 0 && rdt[c] !== exp_q[c]) bad = c;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s rd_data trace: cycle %0d got %b want %b", nm, bad + 1, rdt[bad], exp_q[bad]);
    end
    dc = 0; rc = 0; ec = 0; busy_ok = 1'b1;
    foreach (dnt[c]) begin
      if (dnt[c] === 1'b1) dc++;
      if (ryt[c] === 1'b1) rc++;
      if (ert[c] === 1'b1) ec++;
      if (c < L && byt[c] !== 1'b1) busy_ok = 1'b0;
    end
    n_cmp++;
    if (dnt[L] !== 1'b1 || dc != 1) begin
      n_bad++;
      $display("FAIL %s tx_done: at cycle %0d got %b with %0d pulses, want 1 with 1 pulse", nm, L + 1, dnt[L], dc);
    end
    n_cmp++;
    if (rdt[L] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s rd_data after frame: got %b want 1", nm, rdt[L]);
    end
    n_cmp++;
    if (!busy_ok || byt[L] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s tx_busy: during=%0d end=%b want during=1 end=0", nm, busy_ok, byt[L]);
    end
    n_cmp++;
    if (rc != exp_ready) begin
      n_bad++;
      $display("FAIL %s bit_ready pulses: got %0d want %0d", nm, rc, exp_ready);
    end
    n_cmp++;
    if (ec != 0) begin
      n_bad++;
      $display("FAIL %s tx_err pulses: got %0d want 0", nm, ec);
    end
  endtask

  task automatic run_frame(input string nm, input bit pre, input int spur);
    idx = 0;
    src_valid = 1'b1;
    abort_at = -1;
    spur_start_at = spur;
    build_frame(pre);
    step();
    tx_pre   = pre;
    tx_start = 1'b1;
    present();
    capture(exp_q.size() + 3);
    check_frame(nm, nbits);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_start = 0; tx_pre = 0; tx_rst_req = 0;
    bit_data = 0; bit_valid = 0; bit_last = 0;
    repeat (3) step();
    n_cmp++; if (rd_data !== 1'b1)   begin n_bad++; $display("FAIL reset rd_data: got %b want 1", rd_data); end
    n_cmp++; if (tx_busy !== 1'b0)   begin n_bad++; $display("FAIL reset tx_busy: got %b want 0", tx_busy); end
    n_cmp++; if (tx_done !== 1'b0)   begin n_bad++; $display("FAIL reset tx_done: got %b want 0", tx_done); end
    n_cmp++; if (tx_err !== 1'b0)    begin n_bad++; $display("FAIL reset tx_err: got %b want 0", tx_err); end
    n_cmp++; if (bit_ready !== 1'b0) begin n_bad++; $display("FAIL reset bit_ready: got %b want 0", bit_ready); end
    @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (2) step();
    n_cmp++;
    if (rd_data !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle after reset: rd_data=%b tx_busy=%b want 1/0", rd_data, tx_busy);
    end
  endtask

  task automatic test_frame_sync_10();
    nbits = 2;
    bits_a[0] = 1'b1;
    bits_a[1] = 1'b0;
    run_frame("fsync_10", 1'b0, -1);
  endtask

  task automatic test_preamble_1bit();
    int first;
    nbits = 1;
    bits_a[0] = 1'b1;
    run_frame("pre_1", 1'b1, -1);
    first = -1;
    foreach (dnt[c]) if (first < 0 && dnt[c] === 1'b1) first = c;
    n_cmp++;
    if (first != 7375) begin
      n_bad++;
      $display("FAIL pre_1 frame length: got %0d want 7375", first);
    end
  endtask

  task automatic test_random_frames();
    for (int t = 0; t < 3; t++) begin
      nbits = $urandom_range(1, 3);
      for (int k = 0; k < nbits; k++) bits_a[k] = 1'($urandom_range(0, 1));
      run_frame($sformatf("rand_%0d", t), 1'($urandom_range(0, 1)), $urandom_range(2, 600));
    end
  endtask

  task automatic test_rst_from_idle();
    int run, mx;
    nbits = 0;
    idx = 0;
    src_valid = 1'b1;
    abort_at = -1;
    spur_start_at = -1;
    exp_q.delete();
    push_lvl(1'b0, RST_LOW);
    step();
    tx_pre     = 1'b1;
    tx_start   = 1'b1;
    tx_rst_req = 1'b1;
    present();
    capture(RST_LOW + 3);
    check_frame("rst_idle", 0);
    run = 0; mx = 0;
    foreach (rdt[c]) begin
      run = (rdt[c] === 1'b0) ? run + 1 : 0;
      if (run > mx) mx = run;
    end
    n_cmp++;
    if (mx < 5002) begin
      n_bad++;
      $display("FAIL rst_idle loopback sys_rst: longest low %0d, want >= 5002", mx);
    end
  endtask

  task automatic test_abort_rtcal();
    int a;
    nbits = 1;
    bits_a[0] = 1'($urandom_range(0, 1));
    a = $urandom_range(1260, 3120);
    build_frame(1'b0);
    while (exp_q.size() > a) void'(exp_q.pop_back());
    push_lvl(1'b0, RST_LOW);
    idx = 0;
    src_valid = 1'b1;
    abort_at = a;
    spur_start_at = -1;
    step();
    tx_pre   = 1'b0;
    tx_start = 1'b1;
    present();
    capture(exp_q.size() + 3);
    abort_at = -1;
    check_frame("abort_rtcal", 0);
  endtask

  task automatic test_underrun();
    int bad, dc, ec;
    nbits = 1;
    bits_a[0] = 1'($urandom_range(0, 1));
    build_frame(1'b0);
    while (exp_q.size() > 3125) void'(exp_q.pop_back());
    idx = 0;
    src_valid = 1'b0;
    abort_at = -1;
    spur_start_at = -1;
    step();
    tx_pre   = 1'b0;
    tx_start = 1'b1;
    present();
    capture(3130);
    src_valid = 1'b1;
    bad = -1;
    for (int c = 0; c < 3125; c++) if (bad < 0 && rdt[c] !== exp_q[c]) bad = c;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL underrun rd_data trace: cycle %0d got %b want %b", bad + 1, rdt[bad], exp_q[bad]);
    end
    dc = 0; ec = 0;
    foreach (dnt[c]) begin
      if (dnt[c] === 1'b1) dc++;
      if (ert[c] === 1'b1) ec++;
    end
    n_cmp++;
    if (ryt[3125] !== 1'b1) begin n_bad++; $display("FAIL underrun bit_ready at load: got %b want 1", ryt[3125]); end
    n_cmp++;
    if (ert[3126] !== 1'b1 || ec != 1) begin
      n_bad++;
      $display("FAIL underrun tx_err: got %b with %0d pulses, want 1 with 1 pulse", ert[3126], ec);
    end
    n_cmp++;
    if (rdt[3125] !== 1'b1 || rdt[3126] !== 1'b1 || byt[3126] !== 1'b0) begin
      n_bad++;
      $display("FAIL underrun line/busy: rd=%b%b busy=%b want rd=11 busy=0", rdt[3125], rdt[3126], byt[3126]);
    end
    n_cmp++;
    if (dc != 0) begin n_bad++; $display("FAIL underrun tx_done pulses: got %0d want 0", dc); end
  endtask

  task automatic test_reset_mid();
    int k;
    nbits = 1;
    bits_a[0] = 1'($urandom_range(0, 1));
    idx = 0;
    src_valid = 1'b1;
    k = $urandom_range(2, 600);
    step();
    tx_pre   = 1'($urandom_range(0, 1));
    tx_start = 1'b1;
    present();
    for (int c = 1; c <= k; c++) begin
      step();
      tx_start = 1'b0;
    end
    #4;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_data !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid outputs: rd=%b busy=%b done=%b want 1/0/0", rd_data, tx_busy, tx_done);
    end
    @(negedge clk_50m);
    rst_n = 1'b1;
    step();
    run_frame("after_reset", 1'($urandom_range(0, 1)), -1);
  endtask

  initial begin
    abort_at = -1;
    spur_start_at = -1;
    src_valid = 1'b1;
    nbits = 0;
    idx = 0;
    test_reset();
    test_frame_sync_10();
    test_preamble_1bit();
    test_random_frames();
    test_rst_from_idle();
    test_abort_rtcal();
    test_underrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
